// File: rtl/joypad_serial_reader_pkg.sv
// Shared NES pad definitions: reader FSM states and button bit indices, laid out
// so the CPU memory block can serialize the same bit order back on $4016 reads.
package joypad_serial_reader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        SETTLE = 3'd2,
        CLK_LO = 3'd3,
        CLK_HI = 3'd4,
        DONE   = 3'd5
    } joypad_state_e;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int NUM_BUTTONS = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/joypad_serial_reader_cpu_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; RESET_VALUE sets the
// level both flops hold in reset so the consumer sees a benign idle value.
module cpu_sync2 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make the two flops sample simultaneously;
    // blocking here would collapse the chain into a single flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/joypad_serial_reader.sv
// Host side of the NES pad link: latches the CD4021, clocks out eight bits,
// and commits the decoded button levels atomically once per poll.
module joypad_serial_reader
    import joypad_serial_reader_pkg::*;
#(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int POLL_CYCLES  = 833333
) (
    input  logic clock,
    input  logic reset_n,
    input  logic poll_now,
    input  logic pad_data,
    output logic pad_latch,
    output logic pad_clk,
    output logic A,
    output logic B,
    output logic select,
    output logic start,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic buttons_valid,
    output logic busy
);

    localparam int TIMER_W = $clog2(POLL_CYCLES);
    localparam int PHASE_W = $clog2(max_int(LATCH_CYCLES, HALF_CYCLES));
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_CYCLES - 1);

    joypad_state_e state, state_next;

    logic [TIMER_W-1:0]     poll_timer;
    logic                   poll_req;
    logic [PHASE_W-1:0]     phase;
    logic [PHASE_W-1:0]     phase_load;
    logic                   phase_done;
    logic [2:0]             bit_count;
    logic [NUM_BUTTONS-1:0] shift_reg;
    logic [NUM_BUTTONS-1:0] button_reg;
    logic                   valid_reg;
    logic                   pad_sync;

    // Released (1) in reset so a poll right after reset never sees a phantom press.
    cpu_sync2 #(.RESET_VALUE(1'b1)) u_pad_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (pad_data),
        .q       (pad_sync)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            poll_timer <= '0;
        end else if (poll_timer == TIMER_LAST) begin
            poll_timer <= '0;
        end else begin
            poll_timer <= poll_timer + TIMER_W'(1);
        end
    end

    assign poll_req   = (poll_timer == TIMER_LAST);
    assign phase_done = (phase == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Requests seen outside IDLE fall through the default hold and are lost.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (poll_req || poll_now) state_next = LATCH;
            LATCH:   if (phase_done) state_next = SETTLE;
            SETTLE:  if (phase_done) state_next = CLK_LO;
            CLK_LO:  if (phase_done) state_next = CLK_HI;
            CLK_HI:  if (phase_done) state_next = (bit_count == 3'd6) ? DONE : CLK_LO;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        pad_latch = 1'b0;
        pad_clk   = 1'b1;
        busy      = (state != IDLE);
        case (state)
            LATCH:   pad_latch = 1'b1;
            CLK_LO:  pad_clk   = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        phase_load = '0;
        case (state_next)
            LATCH:                  phase_load = PHASE_W'(LATCH_CYCLES - 1);
            SETTLE, CLK_LO, CLK_HI: phase_load = PHASE_W'(HALF_CYCLES - 1);
            default:                phase_load = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase      <= '0;
            bit_count  <= '0;
            shift_reg  <= '0;
            button_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (state_next != state) begin
                phase <= phase_load;
            end else if (!phase_done) begin
                phase <= phase - PHASE_W'(1);
            end
            // Each bit is captured on the last cycle of its window, when the pad
            // output has been stable for most of a half-period.
            case (state)
                IDLE: begin
                    if (state_next == LATCH) begin
                        bit_count <= '0;
                        shift_reg <= '0;
                    end
                end
                SETTLE: begin
                    if (phase_done) shift_reg[BTN_A] <= pad_sync;
                end
                CLK_HI: begin
                    if (phase_done) begin
                        shift_reg[bit_count + 3'd1] <= pad_sync;
                        bit_count                   <= bit_count + 3'd1;
                    end
                end
                DONE: begin
                    button_reg <= ~shift_reg;
                    valid_reg  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign A             = button_reg[BTN_A];
    assign B             = button_reg[BTN_B];
    assign select        = button_reg[BTN_SELECT];
    assign start         = button_reg[BTN_START];
    assign up            = button_reg[BTN_UP];
    assign down          = button_reg[BTN_DOWN];
    assign left          = button_reg[BTN_LEFT];
    assign right         = button_reg[BTN_RIGHT];
    assign buttons_valid = valid_reg;

endmodule

// File: tb/tb_joypad_serial_reader.sv
// Bench for joypad_serial_reader: a CD4021 pad model drives pad_data, and a poll-level
// model predicts every output on every cycle from the poll timing and the latched word.
module tb_joypad_serial_reader;

    localparam int L = 4;
    localparam int H = 4;
    localparam int P = 200;
    localparam int POLL_LEN = L + 15 * H + 1;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic poll_now = 1'b0;
    logic pad_data;
    logic pad_latch, pad_clk, buttons_valid, busy;
    logic A, B, select, start, up, down, left, right;
    logic [7:0] btns;

    logic [7:0] pad_word = 8'hFF;
    logic [7:0] pad_sr = 8'hFF;
    logic glitch = 1'b0;
    logic glitch_en = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    joypad_serial_reader #(
        .LATCH_CYCLES (L),
        .HALF_CYCLES  (H),
        .POLL_CYCLES  (P)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .poll_now      (poll_now),
        .pad_data      (pad_data),
        .pad_latch     (pad_latch),
        .pad_clk       (pad_clk),
        .A             (A),
        .B             (B),
        .select        (select),
        .start         (start),
        .up            (up),
        .down          (down),
        .left          (left),
        .right         (right),
        .buttons_valid (buttons_valid),
        .busy          (busy)
    );

    assign btns = {right, left, down, up, start, select, B, A};

    // CD4021: parallel load while latch is high, shift toward the output on pad_clk
    // rising, serial input tied high. Output is active-low.
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) pad_sr <= pad_word;
        else           pad_sr <= {1'b1, pad_sr[7:1]};
    end

    // Glitch spans the second clock edge of a low half-period, far from any sample point.
    always @(negedge pad_clk) begin
        if (glitch_en) begin
            #13 glitch <= 1'b1;
            #14 glitch <= 1'b0;
        end
    end

    assign pad_data = pad_sr[0] ^ glitch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Poll-level model: m_k is the cycle index inside a poll (-1 when idle).
    int         m_k = -1;
    int         m_tmr = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_buttons = 8'h00;
    logic [7:0] m_word = 8'hFF;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_k       <= -1;
            m_tmr     <= 0;
            m_valid   <= 1'b0;
            m_buttons <= 8'h00;
            m_word    <= 8'hFF;
        end else begin
            m_tmr   <= (m_tmr == P - 1) ? 0 : m_tmr + 1;
            m_valid <= 1'b0;
            if (m_k < 0) begin
                if (m_tmr == P - 1 || poll_now) begin
                    m_k    <= 0;
                    m_word <= pad_word;
                end
            end else if (m_k == POLL_LEN - 1) begin
                m_k       <= -1;
                m_valid   <= 1'b1;
                m_buttons <= ~m_word;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // {busy, pad_latch, pad_clk} as a function of position in the poll.
    function automatic logic [2:0] exp_pins(input int k);
        logic b, l, c;
        b = (k >= 0);
        l = (k >= 0) && (k < L);
        c = 1'b1;
        if (k >= L + H && k < L + 15 * H && ((k - L - H) / H) % 2 == 0) c = 1'b0;
        return {b, l, c};
    endfunction

    always @(negedge clock) begin
        check("pins", {28'd0, busy, pad_latch, pad_clk, buttons_valid}, {28'd0, exp_pins(m_k), m_valid});
        check("buttons", {24'd0, btns}, {24'd0, m_buttons});
    end

    // Pin monitor for protocol-shape checks.
    logic mon_clr = 1'b0;
    int   lat_cycles = 0, low_pulses = 0, bad_runs = 0, run_len = 0;
    int   valid_pulses = 0, busy_cycles = 0;
    logic prev_clk = 1'b1;

    always @(negedge clock) begin
        if (mon_clr) begin
            lat_cycles   <= 0;
            low_pulses   <= 0;
            bad_runs     <= 0;
            run_len      <= 0;
            valid_pulses <= 0;
            busy_cycles  <= 0;
        end else begin
            if (pad_latch)     lat_cycles   <= lat_cycles + 1;
            if (buttons_valid) valid_pulses <= valid_pulses + 1;
            if (busy)          busy_cycles  <= busy_cycles + 1;
            if (!pad_clk) begin
                run_len <= prev_clk ? 1 : run_len + 1;
                if (prev_clk) low_pulses <= low_pulses + 1;
            end else if (!prev_clk && run_len != H) begin
                bad_runs <= bad_runs + 1;
            end
        end
        prev_clk <= pad_clk;
    end

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge clock);
        #1 mon_clr = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            if (m_k < 0) return;
            @(negedge clock);
        end
        check("idle_timeout", 32'(m_k < 0), 32'd1);
    endtask

    task automatic wait_valid(input int bound, output int n_seen);
        n_seen = 0;
        for (int n = 1; n <= bound; n++) begin
            @(negedge clock);
            if (buttons_valid) begin
                n_seen = n;
                break;
            end
        end
        check("valid_seen", 32'(n_seen != 0), 32'd1);
    endtask

    // Returns the negedge index (1 = first negedge after the sampling edge) of buttons_valid.
    task automatic poll_with(input logic [7:0] word, output int valid_at);
        pad_word = word;
        poll_now = 1'b1;
        valid_at = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clock);
            if (n == 1) poll_now = 1'b0;
            if (buttons_valid) begin
                valid_at = n;
                break;
            end
        end
        check("poll_valid_seen", 32'(valid_at != 0), 32'd1);
    endtask

    initial begin
        int va, vcnt, busy_at_req;
        logic found;
        logic [7:0] exp8;

        #2 reset_n = 1'b0;
        #1;
        check("reset_pins", {28'd0, pad_latch, pad_clk, busy, buttons_valid}, 32'b0100);
        check("reset_buttons", {24'd0, btns}, 32'd0);
        repeat (3) @(negedge clock);
        #1 reset_n = 1'b1;

        // A and start pressed, on demand.
        mon_clear();
        poll_with(8'b1111_0110, va);
        check("t1_latency", va, 32'd66);
        check("t1_buttons", {24'd0, btns}, 32'h09);
        repeat (3) @(negedge clock);
        #1;
        check("t1_latch_cycles", lat_cycles, 32'd4);
        check("t1_clk_pulses", low_pulses, 32'd7);
        check("t1_bad_pulse_len", bad_runs, 32'd0);
        check("t1_valid_pulses", valid_pulses, 32'd1);

        // Disconnected pad, timer-driven polls.
        pad_word = 8'hFF;
        wait_valid(600, va);
        mon_clear();
        wait_valid(600, va);
        check("t2_interval", va + 1, 32'd200);
        check("t2_buttons", {24'd0, btns}, 32'd0);
        @(negedge clock);
        #1;
        check("t2_busy_cycles", busy_cycles, 32'(POLL_LEN));
        check("t2_valid_pulses", valid_pulses, 32'd1);

        // Walking single press across all eight buttons.
        for (int i = 0; i < 8; i++) begin
            exp8 = 8'h01 << i;
            wait_idle();
            poll_with(~exp8, va);
            check("t3_walk", {24'd0, btns}, {24'd0, exp8});
        end

        // poll_now coincident with timer wrap, then again while busy.
        found = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clock);
            if (m_tmr == P - 1 && m_k < 0) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_wrap_found", {31'd0, found}, 32'd1);
        pad_word = 8'h3C;
        poll_now = 1'b1;
        vcnt = 0;
        va = 0;
        busy_at_req = 0;
        for (int n = 1; n <= 150; n++) begin
            @(negedge clock);
            if (n == 1) poll_now = 1'b0;
            if (n == 20) begin
                busy_at_req = busy;
                poll_now = 1'b1;
            end
            if (n == 21) poll_now = 1'b0;
            if (buttons_valid) begin
                vcnt++;
                if (va == 0) va = n;
            end
        end
        check("t4_busy_at_req", busy_at_req, 32'd1);
        check("t4_valid_count", vcnt, 32'd1);
        check("t4_latency", va, 32'd66);
        check("t4_buttons", {24'd0, btns}, 32'hC3);

        // Reset during CLK_LO of bit 3.
        wait_idle();
        pad_word = 8'hA5;
        poll_now = 1'b1;
        @(negedge clock);
        poll_now = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (m_k == 25) break;
            @(negedge clock);
        end
        check("t5_in_clk_lo", {31'd0, pad_clk}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("t5_reset_pins", {28'd0, pad_latch, pad_clk, busy, buttons_valid}, 32'b0100);
        check("t5_reset_buttons", {24'd0, btns}, 32'd0);
        repeat (3) @(negedge clock);
        #1 reset_n = 1'b1;
        poll_with(8'hA5, va);
        check("t5_latency", va, 32'd66);
        check("t5_buttons", {24'd0, btns}, 32'h5A);

        // Asynchronous glitches on pad_data away from the sample points.
        glitch_en = 1'b1;
        wait_idle();
        poll_with(8'h69, va);
        check("t6_latency", va, 32'd66);
        check("t6_buttons", {24'd0, btns}, 32'h96);
        glitch_en = 1'b0;

        repeat (5) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/joypad_serial_reader.md
Name: joypad_serial_reader

Overview:
- Host side of the NES controller link: drives latch and clock pins on a physical NES pad (CD4021 shift register) and deserializes its 8 button bits.
- Outputs are eight level signals that feed the CPU memory block's button inputs. That block in turn serializes them back to the CPU on $4016 reads.
- Polls autonomously at a fixed frame-rate period, or on demand.

Parameters:
- LATCH_CYCLES, 600, clocks pad_latch is held high (12 us at 50 MHz).
- HALF_CYCLES, 300, clocks per pad_clk half-period and per settle window (6 us).
- POLL_CYCLES, 833333, clocks between automatic polls (~60 Hz at 50 MHz); must exceed LATCH_CYCLES + 16*HALF_CYCLES.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- poll_now  in  1  single-cycle request to start a poll immediately
- pad_data  in  1  serial data from pad, asynchronous, active-low (0 = pressed)
- pad_latch  out  1  parallel-load strobe to pad, active-high
- pad_clk  out  1  shift clock to pad, idles high; pad shifts on rising edge
- A, B, select, start, up, down, left, right  out  1 each  debounced-by-frame button levels, 1 = pressed
- buttons_valid  out  1  one-cycle pulse when a new button set is committed
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Clock and reset: one clock, `clock`; reset `reset_n` is asynchronous, active-low. All flops clear on negedge reset_n.
- Reset values:
  - pad_latch=0, pad_clk=1.
  - All buttons=0, buttons_valid=0, busy=0.
  - FSM=IDLE; poll timer=0; shift reg=0; bit count=0.
- Synchronizer: pad_data passes through a 2-flop synchronizer (reset value 1 = released) before sampling. Its 2-cycle latency is negligible against HALF_CYCLES; HALF_CYCLES >= 4 is required.
- Poll timer: free-running, counts 0..POLL_CYCLES-1 and wraps; terminal count raises poll_req.
  - poll_req or poll_now in IDLE starts a poll.
  - Requests arriving while busy are dropped, not queued.
  - Timer and poll_now in the same cycle start exactly one poll.
- Phase counter: counts down; reloaded on every state entry.
- FSM states and transitions:
  - IDLE: latch=0, clk=1. Leaves on a poll request -> LATCH (load LATCH_CYCLES-1).
  - LATCH: latch=1, clk=1 for LATCH_CYCLES clocks -> SETTLE.
  - SETTLE: latch=0, clk=1 for HALF_CYCLES. On the final cycle, sample the synchronized data into bit 0 (A) -> CLK_LO.
  - CLK_LO: clk=0 for HALF_CYCLES -> CLK_HI.
  - CLK_HI: clk=1 for HALF_CYCLES. On the final cycle, sample into bit index count+1 and increment count. If count reaches 7 -> DONE, else -> CLK_LO.
  - DONE: one cycle. Commit the inverted shift register to the outputs, pulse buttons_valid -> IDLE.
- Pad protocol totals: exactly 7 falling/rising pad_clk pulses and 8 samples per poll.
- Bit order: 0=A, 1=B, 2=select, 3=start, 4=up, 5=down, 6=left, 7=right.
- Poll duration: LATCH_CYCLES + 15*HALF_CYCLES + 1 clocks from leaving IDLE to buttons_valid.
- Commit rule: button outputs change only in DONE, all eight atomically. They hold between polls.
- Disconnected pad: pad_data floats high (pull-up), which yields all buttons 0.
- Reset mid-poll: immediate return to reset values. The partial shift data is discarded, and the next poll starts from the timer's next wrap.

Decomposition:
- Shared package:
  - joypad FSM state enum {IDLE, LATCH, SETTLE, CLK_LO, CLK_HI, DONE}, 3-bit.
  - Button index constants BTN_A..BTN_RIGHT (0..7).
  - These go alongside the existing CPU/PPU defines so the CPU memory block can use the same indices.
- Sub-module: cpu_sync2, a 2-flop synchronizer with a reset-value parameter, reusable for other async inputs.
- Counter widths: $clog2 of each parameter.

Test Plan (sim params LATCH_CYCLES=4, HALF_CYCLES=4, POLL_CYCLES=200; behavioural 4021 model loads on latch high and shifts on pad_clk rising):
- Pad drives A and start pressed (active-low word 8'b1111_0110), poll_now pulsed -> after 4+60+1=65 cycles, buttons_valid pulses once; A=1, start=1, others 0. Check pad_latch high for exactly 4 cycles and exactly 7 pad_clk low pulses, each 4 cycles.
- All released (pad_data constantly 1), timer-driven -> buttons_valid every 200 cycles, all outputs 0, busy low between polls.
- Walking-one press, one button per poll across 8 polls -> outputs walk A, B, select, start, up, down, left, right; no output glitches between DONE commits.
- poll_now asserted on the same cycle as timer wrap, and again while busy -> exactly one poll; the busy-time request is ignored.
- reset_n pulled low during CLK_LO of bit 3 -> immediately pad_latch=0, pad_clk=1, buttons=0, busy=0; after release, the next poll completes normally with the correct pattern.
- pad_data toggled asynchronously mid-half-period (not at sample point) -> sampled values match the model's level at each sample cycle.
